// File: rtl/hash_arb.sv
// hash_arb: two-requester round-robin scheduler for the SHA-384/512 engine.
// It queues one job per requester, issues the winning job to the engine,
// waits for completion and returns a one-hot ack to the job's owner.
// Optional watchdog: define HASH_ARB_TMO_EN to add the WAIT timeout and the
// TERR state (err pulse plus engine clear). Without it, err is tied to zero.
module hash_arb #(
    parameter int unsigned TMO_CYCLES = 4096,
    parameter int unsigned TMO_W      = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [4:0] req_op0,
    input  logic [4:0] req_op1,
    input  logic       abort,
    input  logic       hash_rdy,
    input  logic       hash_done,
    output logic       hash_en,
    output logic [4:0] hash_op,
    output logic       hash_clr,
    output logic       sel,
    output logic       busy,
    output logic [1:0] ack,
    output logic [1:0] err
);

    localparam int unsigned N_REQ = 2;
    localparam int unsigned OP_W  = 5;

`ifdef HASH_ARB_TMO_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_CLR   = 3'd4,
        S_TERR  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_CLR   = 3'd4
    } state_t;
`endif

    // Watchdog sizing check: this marker block only appears when the counter
    // is too narrow to reach the limit.
    if ((64'(1) << TMO_W) <= 64'(TMO_CYCLES)) begin : g_tmo_cfg_illegal
    end

    state_t            state;
    state_t            state_d;

    logic [N_REQ-1:0]  pend;
    logic [N_REQ-1:0]  pend_d;
    logic [OP_W-1:0]   op0_q;
    logic [OP_W-1:0]   op1_q;
    logic              last;
    logic              rdy_q;

    logic              grant_c;
    logic              gnt_idx_c;
    logic [OP_W-1:0]   gnt_op_c;

    logic              hash_en_d;
    logic [OP_W-1:0]   hash_op_d;
    logic              hash_clr_d;
    logic              sel_d;
    logic              busy_d;
    logic [N_REQ-1:0]  ack_d;
    logic              last_d;

`ifdef HASH_ARB_TMO_EN
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit_c;
    logic [N_REQ-1:0]  err_d;
    logic [N_REQ-1:0]  err_q;
`endif

    // Arbitration: the single pending requester, or the one not served last.
    always_comb begin
        gnt_idx_c = (pend == 2'b11) ? ~last : pend[1];
        gnt_op_c  = gnt_idx_c ? op1_q : op0_q;
        grant_c   = (state == S_IDLE) && !abort && rdy_q && (pend != '0);
    end

    // Pending flags: grant clears, a new request sets (set wins), abort flushes.
    always_comb begin
        pend_d = pend;
        if (grant_c) begin
            pend_d[gnt_idx_c] = 1'b0;
        end
        pend_d = pend_d | req;
        if (abort) begin
            pend_d = '0;
        end
    end

    // Request queue, op capture and engine-ready sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            op0_q <= '0;
            op1_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            pend  <= pend_d;
            rdy_q <= hash_rdy;
            if (req[0]) begin
                op0_q <= req_op0;
            end
            if (req[1]) begin
                op1_q <= req_op1;
            end
        end
    end

`ifdef HASH_ARB_TMO_EN
    assign tmo_hit_c = (tmo_cnt == TMO_W'(TMO_CYCLES - 1));

    // Watchdog: zero outside WAIT, counts every WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != S_WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM next state; abort overrides every state.
    always_comb begin
        state_d = state;
        if (abort) begin
            state_d = S_CLR;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_c) begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: begin
                    if (hash_done) begin
                        state_d = S_DONE;
                    end
`ifdef HASH_ARB_TMO_EN
                    else if (tmo_hit_c) begin
                        state_d = S_TERR;
                    end
`endif
                end
                S_DONE:  state_d = S_IDLE;
                S_CLR:   state_d = S_IDLE;
`ifdef HASH_ARB_TMO_EN
                S_TERR:  state_d = S_IDLE;
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs: next values of the registered outputs, keyed on the state entered.
    always_comb begin
        hash_en_d  = 1'b0;
        hash_clr_d = 1'b0;
        busy_d     = (state_d != S_IDLE);
        ack_d      = '0;
        sel_d      = sel;
        hash_op_d  = hash_op;
        last_d     = last;
`ifdef HASH_ARB_TMO_EN
        err_d      = '0;
`endif
        if (grant_c) begin
            sel_d     = gnt_idx_c;
            hash_op_d = gnt_op_c;
        end
        case (state_d)
            S_ISSUE: hash_en_d = 1'b1;
            S_DONE: begin
                ack_d  = sel ? 2'b10 : 2'b01;
                last_d = sel;
            end
            S_CLR: hash_clr_d = 1'b1;
`ifdef HASH_ARB_TMO_EN
            S_TERR: begin
                err_d      = sel ? 2'b10 : 2'b01;
                hash_clr_d = 1'b1;
                last_d     = sel;
            end
`endif
            default: begin
            end
        endcase
    end

    // Output and round-robin history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hash_en  <= 1'b0;
            hash_op  <= '0;
            hash_clr <= 1'b0;
            sel      <= 1'b0;
            busy     <= 1'b0;
            ack      <= '0;
            last     <= 1'b1;
        end else begin
            hash_en  <= hash_en_d;
            hash_op  <= hash_op_d;
            hash_clr <= hash_clr_d;
            sel      <= sel_d;
            busy     <= busy_d;
            ack      <= ack_d;
            last     <= last_d;
        end
    end

`ifdef HASH_ARB_TMO_EN
    // Timeout pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = '0;
`endif

endmodule

// File: tb/tb_hash_arb.sv
// Bench for hash_arb: directed jobs, a cycle-level expectation model of the
// scheduler behaviour, and literal checks pinning key latencies.
module tb_hash_arb;

    localparam int unsigned TMO_CYCLES = 16;
    localparam int unsigned TMO_W      = 5;
`ifdef HASH_ARB_TMO_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = '0;
    logic [4:0] req_op0 = '0;
    logic [4:0] req_op1 = '0;
    logic       abort = 1'b0;
    logic       hash_rdy = 1'b1;
    logic       hash_done = 1'b0;
    logic       hash_en;
    logic [4:0] hash_op;
    logic       hash_clr;
    logic       sel;
    logic       busy;
    logic [1:0] ack;
    logic [1:0] err;

    int n_vec  = 0;
    int n_miss = 0;
    logic chk_on = 1'b0;

    hash_arb #(
        .TMO_CYCLES (TMO_CYCLES),
        .TMO_W      (TMO_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .abort     (abort),
        .hash_rdy  (hash_rdy),
        .hash_done (hash_done),
        .hash_en   (hash_en),
        .hash_op   (hash_op),
        .hash_clr  (hash_clr),
        .sel       (sel),
        .busy      (busy),
        .ack       (ack),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Expectation model: job queue plus the expected outputs of the current cycle.
    logic [1:0] m_pend;
    logic [4:0] m_opq [2];
    logic       m_last;
    logic       m_rdy_prev;
    bit         m_job;
    int         m_wait;
    int         m_g;
    logic       e_en, e_sel, e_clr, e_busy;
    logic [4:0] e_op;
    logic [1:0] e_ack, e_err;
    logic       n_en, n_sel, n_clr, n_busy;
    logic [4:0] n_op;
    logic [1:0] n_ack, n_err;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pend = '0; m_opq[0] = '0; m_opq[1] = '0; m_last = 1'b1;
            m_rdy_prev = 1'b0; m_job = 0; m_wait = 0;
            e_en = 0; e_op = '0; e_sel = 0; e_clr = 0; e_busy = 0; e_ack = '0; e_err = '0;
        end else begin
            n_en = 0; n_clr = 0; n_busy = 0; n_ack = '0; n_err = '0;
            n_sel = e_sel; n_op = e_op; m_g = -1;
            if (abort) begin
                n_clr = 1; n_busy = 1; m_job = 0;
            end else if (!e_busy) begin
                if (m_rdy_prev && m_pend != 2'b00) begin
                    if (m_pend == 2'b11) m_g = m_last ? 0 : 1;
                    else m_g = m_pend[1] ? 1 : 0;
                    n_sel = (m_g == 1); n_op = m_opq[m_g];
                    n_en = 1; n_busy = 1; m_job = 1; m_wait = 0;
                end
            end else if (m_job && !e_en) begin
                if (hash_done) begin
                    n_ack[e_sel] = 1'b1; m_last = e_sel; n_busy = 1; m_job = 0;
                end else if (TMO_ON && m_wait == int'(TMO_CYCLES) - 1) begin
                    n_err[e_sel] = 1'b1; n_clr = 1; m_last = e_sel; n_busy = 1; m_job = 0;
                end else begin
                    m_wait++; n_busy = 1;
                end
            end else if (m_job) begin
                n_busy = 1;
            end
            if (m_g >= 0) m_pend[m_g] = 1'b0;
            if (req[0]) begin m_pend[0] = 1'b1; m_opq[0] = req_op0; end
            if (req[1]) begin m_pend[1] = 1'b1; m_opq[1] = req_op1; end
            if (abort) m_pend = '0;
            m_rdy_prev = hash_rdy;
            e_en = n_en; e_op = n_op; e_sel = n_sel; e_clr = n_clr;
            e_busy = n_busy; e_ack = n_ack; e_err = n_err;
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always begin
        @(negedge clk);
        if (chk_on) begin
            n_vec++;
            if ({hash_en, hash_op, sel, hash_clr, busy, ack, err} !==
                {e_en, e_op, e_sel, e_clr, e_busy, e_ack, e_err}) begin
                n_miss++;
                $display("FAIL model t=%0t got en=%b op=%h sel=%b clr=%b busy=%b ack=%b err=%b want en=%b op=%h sel=%b clr=%b busy=%b ack=%b err=%b",
                         $time, hash_en, hash_op, sel, hash_clr, busy, ack, err,
                         e_en, e_op, e_sel, e_clr, e_busy, e_ack, e_err);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Advance n cycles; single-cycle pulses are dropped after each edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            req = '0;
            abort = 1'b0;
            hash_done = 1'b0;
        end
    endtask

    // Wait (bounded) for the issue pulse, then complete the job after dly cycles.
    task automatic finish_job(input int dly);
        int n = 0;
        while (hash_en !== 1'b1 && n < 30) begin
            tick(1);
            n++;
        end
        n_vec++;
        if (hash_en !== 1'b1) begin
            n_miss++;
            $display("FAIL finish_job_en got hash_en=%b want 1 within 30 cycles", hash_en);
        end else begin
            tick(dly);
            hash_done = 1'b1;
            tick(1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got no end of test want $finish before 100us");
        $fatal(1);
    end

    initial begin
        int ens;
        int busy_lo;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        tick(1);
        lit("reset_outputs", {27'd0, hash_en, hash_op, sel, hash_clr, busy, ack, err}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single job: en at t+2, ack at d+1, idle at d+2.
        req = 2'b01; req_op0 = 5'h05;
        tick(2);
        lit("single_en", {hash_en, hash_op, sel}, {1'b1, 5'h05, 1'b0});
        tick(8);
        hash_done = 1'b1;
        tick(1);
        lit("single_ack", ack, 2'b01);
        tick(1);
        lit("single_idle", busy, 1'b0);

        // Contention after reset: 0, then 1, then 0 again.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        req = 2'b11; req_op0 = 5'h0A; req_op1 = 5'h0B;
        tick(2);
        lit("cont_first", {hash_en, hash_op, sel}, {1'b1, 5'h0A, 1'b0});
        tick(3);
        hash_done = 1'b1;
        tick(1);
        lit("cont_ack0", ack, 2'b01);
        tick(2);
        lit("cont_second", {hash_en, hash_op, sel}, {1'b1, 5'h0B, 1'b1});
        tick(1);
        hash_done = 1'b1;
        tick(1);
        lit("cont_ack1", ack, 2'b10);
        tick(1);
        req = 2'b11; req_op0 = 5'h0C; req_op1 = 5'h0D;
        tick(2);
        lit("cont_alt", {hash_en, hash_op, sel}, {1'b1, 5'h0C, 1'b0});
        finish_job(2);
        finish_job(2);
        lit("cont_last_ack", ack, 2'b10);

        // Engine not ready: no issue until two cycles after rdy rises.
        hash_rdy = 1'b0;
        req = 2'b01; req_op0 = 5'h03;
        ens = 0;
        repeat (20) begin
            tick(1);
            ens += int'(hash_en);
        end
        lit("notrdy_no_en", ens, 0);
        hash_rdy = 1'b1;
        tick(1);
        lit("notrdy_r1", hash_en, 1'b0);
        tick(1);
        lit("notrdy_r2", {hash_en, hash_op}, {1'b1, 5'h03});
        finish_job(1);

        // Requeue on the granting edge: old op issued now, new op next.
        tick(1);
        req = 2'b01; req_op0 = 5'h07;
        tick(1);
        req = 2'b01; req_op0 = 5'h09;
        tick(1);
        lit("requeue_first", {hash_en, hash_op, sel}, {1'b1, 5'h07, 1'b0});
        tick(2);
        hash_done = 1'b1;
        tick(1);
        lit("requeue_ack", ack, 2'b01);
        tick(2);
        lit("requeue_second", {hash_en, hash_op, sel}, {1'b1, 5'h09, 1'b0});
        finish_job(1);

        // Abort with done in WAIT; a queued job is flushed too.
        tick(1);
        req = 2'b10; req_op1 = 5'h11;
        tick(3);
        req = 2'b01; req_op0 = 5'h04;
        tick(1);
        abort = 1'b1; hash_done = 1'b1;
        tick(1);
        lit("abort_clr", {hash_clr, ack, err, busy}, {1'b1, 2'b00, 2'b00, 1'b1});
        tick(1);
        lit("abort_idle", {hash_clr, ack, busy}, {1'b0, 2'b00, 1'b0});
        ens = 0;
        repeat (5) begin
            tick(1);
            ens += int'(hash_en);
        end
        lit("abort_flush", ens, 0);

        // Abort in CLR stretches the clear; done outside WAIT is ignored.
        abort = 1'b1;
        tick(1);
        lit("clr_a1", hash_clr, 1'b1);
        abort = 1'b1;
        tick(1);
        lit("clr_a2", hash_clr, 1'b1);
        tick(1);
        lit("clr_end", {hash_clr, busy}, {1'b0, 1'b0});
        hash_done = 1'b1;
        tick(1);
        lit("stray_done", {ack, busy}, {2'b00, 1'b0});

        // Requester 1 job with no completion.
        req = 2'b10; req_op1 = 5'h1F;
        tick(2);
        lit("tmo_en", {hash_en, sel, hash_op}, {1'b1, 1'b1, 5'h1F});
`ifdef HASH_ARB_TMO_EN
        tick(16);
        lit("tmo_before", {err, hash_clr}, {2'b00, 1'b0});
        tick(1);
        lit("tmo_err", {err, hash_clr, ack}, {2'b10, 1'b1, 2'b00});
        tick(1);
        lit("tmo_after", {err, hash_clr, busy}, {2'b00, 1'b0, 1'b0});
`else
        busy_lo = 0;
        repeat (40) begin
            tick(1);
            busy_lo += int'(!busy);
        end
        lit("notmo_busy", busy_lo, 0);
        abort = 1'b1;
        tick(2);
        lit("notmo_abort_idle", busy, 1'b0);
`endif

        // Asynchronous reset mid-job, then last=1 restored (0 wins the tie).
        req = 2'b10; req_op1 = 5'h15;
        tick(4);
        lit("arst_pre", {sel, busy, hash_op}, {1'b1, 1'b1, 5'h15});
        rst_n = 1'b0;
        #1;
        lit("arst_now", {27'd0, hash_en, hash_op, sel, hash_clr, busy, ack, err}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        req = 2'b11; req_op0 = 5'h01; req_op1 = 5'h02;
        tick(2);
        lit("arst_tie", {hash_en, sel, hash_op}, {1'b1, 1'b0, 5'h01});
        finish_job(2);
        finish_job(2);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hash_arb.md
Name: hash_arb

Overview:
- Two-requester scheduler in front of the SHA-384/512 hash engine.
- Queues job requests, picks one by round-robin, and drives the engine's command pins (enable pulse, 5-bit op, clear).
- Waits for completion, then returns an ack or error pulse to the winner.
- Drives the select used by the upstream msg/key mux, so only one client owns the engine datapath at a time.

Parameters:
- TMO_CYCLES, 4096: watchdog limit in WAIT, in clk cycles. Used only with HASH_ARB_TMO_EN.
- TMO_W, 13: watchdog counter width. Must satisfy 2^TMO_W > TMO_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-requester job pulse, one cycle per job
- req_op0  in  5  op for requester 0, sampled when req[0]=1 (bit4 = external hash_m chaining input)
- req_op1  in  5  op for requester 1, sampled when req[1]=1
- abort  in  1  global abort pulse
- hash_rdy  in  1  engine idle/ready (level)
- hash_done  in  1  engine completion pulse
- hash_en  out  1  engine start pulse
- hash_op  out  5  op presented to the engine
- hash_clr  out  1  engine clear pulse
- sel  out  1  index of the granted requester (mux select)
- busy  out  1  high in every state except IDLE
- ack  out  2  one-hot completion pulse
- err  out  2  one-hot timeout pulse

Behaviour:
- Reset values: state=IDLE, hash_en=0, hash_op=0, hash_clr=0, sel=0, busy=0, ack=0, err=0, pend=0, op0_q=0, op1_q=0, last=1. With last=1, requester 0 wins the first tie.
- Request capture:
  - req[i]=1 sets pend[i] and loads opi_q from req_opi on the same edge.
  - A second req[i] while pend[i]=1 overwrites opi_q; the two jobs merge into one.
  - pend[i] clears on the edge that grants i.
  - If req[i] arrives on that same granting edge, the set wins and the new job stays queued. The granted op is the old opi_q value.
- All outputs are registered. States:
  - IDLE:
    - If hash_rdy=1 and pend!=0, choose g: the single pending index, or ~last if both are pending.
    - Register sel=g, hash_op=opg_q, clear pend[g], go to ISSUE.
    - If hash_rdy=0, hold.
  - ISSUE: hash_en=1 for exactly one cycle. Go to WAIT.
  - WAIT:
    - Hold hash_op and sel stable.
    - On hash_done=1, go to DONE.
    - A hash_done seen in any state other than WAIT is ignored.
  - DONE: ack[sel]=1 for one cycle, last<=sel, go to IDLE.
  - CLR: hash_clr=1 for one cycle, go to IDLE.
- Latency with engine idle and rdy=1:
  - req at cycle t, hash_en high at cycle t+2.
  - hash_done at cycle d, ack high at cycle d+1.
  - Next grant: hash_en no earlier than ack+2.
- abort has highest priority in every state. Including IDLE, it:
  - clears pend,
  - issues no ack and no err,
  - goes to CLR.
  - abort in CLR re-enters CLR, so hash_clr stays high one more cycle.
  - abort and hash_done in the same WAIT cycle: abort wins, no ack.
- hash_op holds its last value in IDLE. sel changes only on a grant.
- Asynchronous reset mid-job returns everything to reset values immediately. hash_clr is not asserted by reset.

Optional Feature:
- HASH_ARB_TMO_EN defined:
  - A TMO_W counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TMO_CYCLES-1 without hash_done, go to TERR.
  - TERR: err[sel]=1 and hash_clr=1 together for one cycle, last<=sel, go to IDLE.
  - hash_done on the same cycle as the limit wins: normal ack, no err.
  - abort overrides TERR.
- HASH_ARB_TMO_EN undefined: no counter and no TERR state. err is tied to 0 and WAIT can last indefinitely.

Test Plan:
- Single job: req=2'b01, req_op0=5'h05, hash_rdy=1 at t → hash_en=1 with hash_op=5'h05, sel=0 at t+2. hash_done at t+10 → ack=2'b01 at t+11, busy=0 at t+12.
- Contention: req=2'b11 at the same cycle after reset → requester 0 served first. The second grant goes to 1 (sel=1, hash_op=req_op1), then the next simultaneous pair goes to 0 again (alternation).
- Engine not ready: pending req with hash_rdy=0 for 20 cycles → no hash_en. hash_rdy rises at r → hash_en at r+2.
- Requeue on grant edge: req[0] pulses again on the edge that grants job 0 → after the first ack, job 0 is re-issued with the new op.
- Abort in WAIT, with hash_done on the same cycle → hash_clr=1 for one cycle, ack=0, err=0, pend=0, back to IDLE, busy=0 the cycle after CLR.
- HASH_ARB_TMO_EN with TMO_CYCLES=16: grant requester 1 and never pulse hash_done → err=2'b10 with hash_clr=1 for one cycle, 17 cycles after hash_en, no ack. Without the macro, same stimulus → stays in WAIT, busy=1 indefinitely.
